// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: captures register writes {addr, data, seq}
// for a consumer; drops and counts writes when full.
//
// Ports:
//   clk, reset (async active-low)
//   wb_en/wb_addr/wb_data : writeback stage register write
//   trace_ready           : consumer accepts head entry
//   clear_ovf             : clears overflow and drop_cnt
//   trace_valid/addr/data/seq : first-word-fall-through head entry
//   count                 : entries stored
//   overflow, drop_cnt    : sticky drop flag, saturating drop count
module wb_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     trace_ready,
  input  logic                     clear_ovf,
  output logic                     trace_valid,
  output logic [4:0]               trace_addr,
  output logic [31:0]              trace_data,
  output logic [15:0]              trace_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [15:0]   seq_mem  [DEPTH];

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   seq_q, seq_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic qual, pop, push, drop, full;

  assign qual = wb_en && (wb_addr != 5'd0);
  assign full = (cnt_q == FULL_C);
  assign pop  = (cnt_q != '0) && trace_ready;
  // A full FIFO still accepts a write when the head leaves this cycle.
  assign push = qual && (!full || pop);
  assign drop = qual && full && !pop;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // Pointers wrap naturally since DEPTH is a power of two.
    if (pop)  rd_d = rd_q + 1'b1;
    if (push) begin
      wr_d  = wr_q + 1'b1;
      seq_d = seq_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A drop in the same cycle as a clear wins.
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clear_ovf ? 8'd1 :
               (drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1;
    end else if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q] <= wb_addr;
      data_mem[wr_q] <= wb_data;
      seq_mem[wr_q]  <= seq_q;
    end
  end

  assign trace_valid = (cnt_q != '0);
  assign trace_addr  = addr_mem[rd_q];
  assign trace_data  = data_mem[rd_q];
  assign trace_seq   = seq_mem[rd_q];
  assign count       = cnt_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_wb_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          trace_ready;
  logic          clear_ovf;
  logic          trace_valid;
  logic [4:0]    trace_addr;
  logic [31:0]   trace_data;
  logic [15:0]   trace_seq;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .trace_ready (trace_ready),
    .clear_ovf   (clear_ovf),
    .trace_valid (trace_valid),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_seq   (trace_seq),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] s;
  } ent_t;

  // Reference state: entries awaiting pop, and spec-level counters.
  ent_t        sb[$];
  int          mcnt;
  int unsigned mpushes;
  bit          movf;
  int          mdrop;
  logic [15:0] last_seq;

  int errors = 0;
  int checks = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    mcnt    = 0;
    mpushes = 0;
    movf    = 0;
    mdrop   = 0;
  endtask

  // Called just after a rising edge; drives one cycle of inputs.
  task automatic step(bit en, logic [4:0] a, logic [31:0] d,
                      bit rdy, bit clr);
    bit qual, pop, push, drop;
    wb_en       = en;
    wb_addr     = a;
    wb_data     = d;
    trace_ready = rdy;
    clear_ovf   = clr;
    qual = en && (a != 0);
    pop  = (mcnt != 0) && rdy;
    push = qual && ((mcnt < DEPTH) || pop);
    drop = qual && !push;
    if (push) sb.push_back('{a, d, 16'(mpushes)});
    @(posedge clk);
    #1;
    if (push) mpushes++;
    mcnt = mcnt + int'(push) - int'(pop);
    if (drop) begin
      movf  = 1;
      mdrop = clr ? 1 : ((mdrop < 255) ? mdrop + 1 : 255);
    end else if (clr) begin
      movf  = 0;
      mdrop = 0;
    end
  endtask

  task automatic idle(bit rdy);
    step(0, 5'd0, 32'd0, rdy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares state against the model and pops the scoreboard
  // whenever the consumer takes the head.
  always @(negedge clk) begin
    if (reset) begin
      chk("count", 64'(count), 64'(mcnt));
      chk("valid", 64'(trace_valid), 64'(mcnt != 0));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      if (trace_valid && trace_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL pop_empty: got pop expected none");
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("head_addr", 64'(trace_addr), 64'(e.a));
          chk("head_data", 64'(trace_data), 64'(e.d));
          chk("head_seq", 64'(trace_seq), 64'(e.s));
          last_seq = trace_seq;
        end
      end
    end
  end

  initial begin
    wb_en = 0; wb_addr = 0; wb_data = 0;
    trace_ready = 0; clear_ovf = 0;
    reset = 1'b0;
    model_clear();
    #2;
    chk("por_valid", 64'(trace_valid), 64'd0);
    chk("por_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Basic push, head visible next cycle
    step(1, 5'd5, 32'hDEADBEEF, 0, 0);
    chk("basic_valid", 64'(trace_valid), 64'd1);
    chk("basic_addr", 64'(trace_addr), 64'd5);
    chk("basic_data", 64'(trace_data), 64'hDEADBEEF);
    chk("basic_seq", 64'(trace_seq), 64'd0);
    chk("basic_count", 64'(count), 64'd1);
    idle(1);

    // x0 filter
    do_reset();
    repeat (3) step(1, 5'd0, 32'h1234, 0, 0);
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_ovf", 64'(overflow), 64'd0);
    step(1, 5'd3, 32'hA5A5, 0, 0);
    chk("x0_next_seq", 64'(trace_seq), 64'd0);
    idle(1);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 10; i++) step(1, 5'(i), $urandom, 0, 0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    repeat (8) idle(1);
    chk("drain_count", 64'(count), 64'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) step(1, 5'(i + 10), $urandom, 0, 0);
    step(1, 5'd20, 32'h2020_2020, 1, 0);
    chk("fpp_count", 64'(count), 64'd8);
    chk("fpp_drop", 64'(drop_cnt), 64'd2);
    repeat (8) idle(1);

    // Saturation and clear
    for (int i = 0; i < 8; i++) step(1, 5'd9, $urandom, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 5'd9, $urandom, 0, 0);
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    step(1, 5'd9, 32'd1, 0, 1);
    chk("clrdrop_ovf", 64'(overflow), 64'd1);
    chk("clrdrop_cnt", 64'(drop_cnt), 64'd1);
    step(0, 5'd0, 32'd0, 0, 1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_cnt", 64'(drop_cnt), 64'd0);
    repeat (8) idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 3) != 0, a, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    repeat (10) idle(1);

    // Sequence wrap with continuous drain
    do_reset();
    for (int i = 0; i < 65537; i++)
      step(1, 5'($urandom_range(1, 31)), $urandom, 1, 0);
    idle(1);
    chk("wrap_last_seq", 64'(last_seq), 64'd0);

    // Reset mid-stream with entries stored
    for (int i = 0; i < 3; i++) step(1, 5'(i + 1), $urandom, 0, 0);
    chk("pre_rst_count", 64'(count), 64'd3);
    do_reset();
    step(1, 5'd7, 32'h77, 0, 0);
    chk("post_rst_seq", 64'(trace_seq), 64'd0);
    chk("post_rst_addr", 64'(trace_addr), 64'd7);
    idle(1);
    idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
